// File: rtl/idli_io_regs_m.sv
// Nibble-serial I/O register bank: NUM_REGS words of WORD_NIBS nibbles, one word per
// transaction LSB nibble first, writes staged in a shadow word and committed atomically.
module idli_io_regs_m #(
    parameter int NUM_REGS  = 4,
    parameter int WORD_NIBS = 4,
    localparam int WORD_BITS = 4 * WORD_NIBS,
    localparam int SEL_W     = $clog2(NUM_REGS),
    localparam int NIB_W     = $clog2(WORD_NIBS)
) (
    input  logic                          i_ioq_gck,
    input  logic                          i_ioq_rst,
    input  logic                          i_ioq_start,
    input  logic [SEL_W-1:0]              i_ioq_sel,
    input  logic                          i_ioq_wr_en,
    input  logic [3:0]                    i_ioq_data,
    output logic [3:0]                    o_ioq_data,
    output logic                          o_ioq_busy,
    output logic [NIB_W-1:0]              o_ioq_nib,
    output logic [NUM_REGS-1:0]           o_ioq_dirty,
    input  logic [NUM_REGS-1:0]           i_ioq_dirty_clr,
    output logic [NUM_REGS*WORD_BITS-1:0] o_ioq_pins
);

    typedef enum logic {IDLE, XFER} state_t;

    localparam logic [NIB_W-1:0] LAST = NIB_W'(WORD_NIBS - 1);

    state_t                 state_q, state_d;
    logic [NIB_W-1:0]       cnt_q, cnt_d;
    logic [SEL_W-1:0]       sel_q, sel_d;
    logic                   wr_q, wr_d;
    logic [WORD_BITS-5:0]   shd_q, shd_d;
    logic [WORD_BITS-1:0]   regs_q [NUM_REGS];
    logic [WORD_BITS-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]    dirty_q, dirty_d;

    logic                   start_ok;
    logic                   xfer_cont;
    logic                   commit;
    logic [SEL_W-1:0]       act_sel;
    logic                   act_wr;
    logic [NIB_W-1:0]       act_nib;
    logic [WORD_BITS-1:0]   rd_word;

    // NOTE: every signal gets a default at the top of the block so no path leaves it unassigned and infers a latch.
    always_comb begin
        start_ok  = i_ioq_start && (state_q == IDLE || cnt_q == LAST);
        xfer_cont = (state_q == XFER) && !start_ok;
        commit    = (state_q == XFER) && (cnt_q == LAST) && wr_q;

        // The accepted-start cycle uses the live inputs; later cycles use the latched ones.
        act_sel = xfer_cont ? sel_q : i_ioq_sel;
        act_wr  = xfer_cont ? wr_q  : i_ioq_wr_en;
        act_nib = xfer_cont ? cnt_q : '0;

        rd_word    = regs_q[act_sel];
        o_ioq_data = rd_word[3:0];
        for (int k = 1; k < WORD_NIBS; k++) begin
            if (act_nib == NIB_W'(k)) o_ioq_data = rd_word[k*4 +: 4];
        end

        shd_d = shd_q;
        if ((start_ok || state_q == XFER) && act_wr) begin
            for (int k = 0; k < WORD_NIBS - 1; k++) begin
                if (act_nib == NIB_W'(k)) shd_d[k*4 +: 4] = i_ioq_data;
            end
        end

        regs_d  = regs_q;
        dirty_d = dirty_q & ~i_ioq_dirty_clr;
        if (commit) begin
            regs_d[sel_q]  = {i_ioq_data, shd_q};
            dirty_d[sel_q] = 1'b1;
        end

        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        wr_d    = wr_q;
        if (start_ok) begin
            state_d = XFER;
            cnt_d   = NIB_W'(1);
            sel_d   = i_ioq_sel;
            wr_d    = i_ioq_wr_en;
        end else if (state_q == XFER) begin
            if (cnt_q == LAST) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + NIB_W'(1);
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_ioq_gck or posedge i_ioq_rst) begin
        if (i_ioq_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            wr_q    <= 1'b0;
            shd_q   <= '0;
            dirty_q <= '0;
            // NOTE: the register array drives pins directly, so it is flop-based and must reset to a known value.
            for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            wr_q    <= wr_d;
            shd_q   <= shd_d;
            dirty_q <= dirty_d;
            for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= regs_d[r];
        end
    end

    assign o_ioq_busy  = (state_q == XFER);
    assign o_ioq_nib   = act_nib;
    assign o_ioq_dirty = dirty_q;

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_pins
        assign o_ioq_pins[r*WORD_BITS +: WORD_BITS] = regs_q[r];
    end

endmodule

// File: tb/tb_idli_io_regs_m.sv
// Directed bench for idli_io_regs_m: default 4x16-bit instance plus an 8x32-bit instance.
module tb_idli_io_regs_m;

    logic         clk = 1'b0;
    logic         rst;

    logic         st, wr;
    logic [1:0]   sel;
    logic [3:0]   din, clr;
    logic [3:0]   dout, dirty;
    logic         busy;
    logic [1:0]   nib;
    logic [63:0]  pins;

    logic         st2, wr2;
    logic [2:0]   sel2;
    logic [3:0]   din2;
    logic [7:0]   clr2, dirty2;
    logic [3:0]   dout2;
    logic         busy2;
    logic [2:0]   nib2;
    logic [255:0] pins2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    idli_io_regs_m u_dut (
        .i_ioq_gck(clk), .i_ioq_rst(rst), .i_ioq_start(st), .i_ioq_sel(sel),
        .i_ioq_wr_en(wr), .i_ioq_data(din), .o_ioq_data(dout), .o_ioq_busy(busy),
        .o_ioq_nib(nib), .o_ioq_dirty(dirty), .i_ioq_dirty_clr(clr), .o_ioq_pins(pins)
    );

    idli_io_regs_m #(.NUM_REGS(8), .WORD_NIBS(8)) u_dut8 (
        .i_ioq_gck(clk), .i_ioq_rst(rst), .i_ioq_start(st2), .i_ioq_sel(sel2),
        .i_ioq_wr_en(wr2), .i_ioq_data(din2), .o_ioq_data(dout2), .o_ioq_busy(busy2),
        .o_ioq_nib(nib2), .o_ioq_dirty(dirty2), .i_ioq_dirty_clr(clr2), .o_ioq_pins(pins2)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive inputs just after an edge, then move to mid-cycle for sampling.
    task automatic drv(input logic s, input logic [1:0] sl, input logic w,
                       input logic [3:0] d, input logic [3:0] c);
        st = s; sel = sl; wr = w; din = d; clr = c;
        #3;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic [15:0] w1 = 16'hABCD;
    logic [15:0] w0 = 16'h1234;
    logic [31:0] w2 = 32'h89ABCDEF;
    int          bc;

    initial begin
        rst = 1'b1;
        st = 0; sel = 0; wr = 0; din = 0; clr = 0;
        st2 = 0; sel2 = 0; wr2 = 0; din2 = 0; clr2 = 0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;

        // Idle read of reg2 straight out of reset.
        for (int k = 0; k < 4; k++) begin
            drv(0, 2, 0, 0, 0);
            check("idle_data", dout, 0);
            check("idle_busy", busy, 0);
            check("idle_nib", nib, 0);
            if (k == 0) begin
                check("rst_pins", pins, 0);
                check("rst_dirty", dirty, 0);
            end
            tick();
        end

        // Write reg1 = 0xABCD; pins stay 0 until the commit edge.
        for (int k = 0; k < 4; k++) begin
            drv(k == 0, 1, 1, w1[k*4 +: 4], 0);
            check("wr1_pins_hold", pins, 0);
            check("wr1_busy", busy, (k != 0));
            check("wr1_nib", nib, k);
            tick();
        end
        drv(0, 1, 0, 0, 0);
        check("wr1_pins", pins, 64'h0000_0000_ABCD_0000);
        check("wr1_dirty", dirty, 4'b0010);
        check("wr1_idle_rd", dout, 4'hD);
        tick();

        // Read reg1 back.
        for (int k = 0; k < 4; k++) begin
            drv(k == 0, 1, 0, 0, 0);
            check("rd1_data", dout, w1[k*4 +: 4]);
            check("rd1_nib", nib, k);
            tick();
        end

        // Write reg0 = 0x1234 with dirty_clr[0] in the commit cycle: set wins.
        for (int k = 0; k < 4; k++) begin
            drv(k == 0, 0, 1, w0[k*4 +: 4], (k == 3) ? 4'b0001 : 4'b0000);
            tick();
        end
        drv(0, 0, 0, 0, 4'b0001);
        check("dirty_set_wins", dirty, 4'b0011);
        tick();
        drv(0, 0, 0, 0, 0);
        check("dirty_clr", dirty, 4'b0010);
        check("wr0_pins", pins, 64'h0000_0000_ABCD_1234);
        tick();

        // Write reg0 again; ignored starts in cycles 1-2; read of reg0 starts on the last cycle.
        for (int k = 0; k < 4; k++) begin
            if (k == 0)      drv(1, 0, 1, w0[k*4 +: 4], 0);
            else if (k == 3) drv(1, 0, 0, w0[k*4 +: 4], 0);
            else             drv(1, 3, 0, w0[k*4 +: 4], 0);
            if (k == 1 || k == 2) begin
                check("b2b_ign_nib", nib, k);
                check("b2b_ign_busy", busy, 1);
            end
            if (k == 3) begin
                check("b2b_rd0_nib", nib, 0);
                check("b2b_rd0_data", dout, 4'h4);
            end
            tick();
        end
        for (int k = 1; k < 4; k++) begin
            drv(0, 0, 0, 0, 0);
            check("b2b_rd_nib", nib, k);
            check("b2b_rd_data", dout, w0[k*4 +: 4]);
            check("b2b_rd_busy", busy, 1);
            tick();
        end
        drv(0, 0, 0, 0, 0);
        check("b2b_end_busy", busy, 0);
        check("b2b_dirty", dirty, 4'b0011);
        check("b2b_pins", pins, 64'h0000_0000_ABCD_1234);
        tick();

        // Reset during cycle 2 of a write of 0xFFFF to reg3.
        for (int k = 0; k < 3; k++) begin
            drv(k == 0, 3, 1, 4'hF, 0);
            if (k == 2) begin
                rst = 1'b1;
                #1;
                check("rst_mid_busy", busy, 0);
                check("rst_mid_nib", nib, 0);
                check("rst_mid_pins", pins, 0);
                check("rst_mid_dirty", dirty, 0);
            end
            tick();
        end
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drv(0, 3, 1, 4'hF, 0);
            check("post_rst_pins", pins, 0);
            check("post_rst_dirty", dirty, 0);
            check("post_rst_busy", busy, 0);
            tick();
        end

        // 8x8 instance: write reg7 = 0x89ABCDEF.
        bc = 0;
        for (int k = 0; k < 8; k++) begin
            st2 = (k == 0); sel2 = 3'd7; wr2 = 1'b1; din2 = w2[k*4 +: 4];
            #3;
            if (busy2) bc++;
            check("p8_nib", nib2, k);
            check("p8_pins_hold", pins2, 0);
            tick();
        end
        st2 = 1'b0; wr2 = 1'b0;
        #3;
        if (busy2) bc++;
        check("p8_busy_cycles", bc, 7);
        check("p8_pins", pins2, {w2, 224'b0});
        check("p8_dirty", dirty2, 8'h80);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/idli_io_regs_m.md
# idli_io_regs_m

Parametrised nibble-serial I/O register bank; the multi-register, reset-capable successor to the single 16-bit serial I/O register. It holds NUM_REGS words of WORD_NIBS nibbles each and transfers one word per transaction over the core's 4-bit serial datapath, least-significant nibble first. Writes are staged in a shadow register and committed atomically on the last nibble, so the parallel pin outputs never show a partially written word. Per-register dirty flags report completed writes to the pad/peripheral side.

## Interface
Parameters:
- NUM_REGS, 4, number of registers; power of two, >= 2
- WORD_NIBS, 4, nibbles per word; power of two, >= 2
- Derived: WORD_BITS = 4*WORD_NIBS; SEL_W = clog2(NUM_REGS); NIB_W = clog2(WORD_NIBS)

Ports:
- i_ioq_gck  in  1  clock, all state on rising edge
- i_ioq_rst  in  1  asynchronous, active-high reset
- i_ioq_start  in  1  begin transaction; this cycle carries nibble 0
- i_ioq_sel  in  SEL_W  target register; sampled only with accepted start
- i_ioq_wr_en  in  1  1 = write, 0 = read; sampled only with accepted start
- i_ioq_data  in  4  write nibble, sampled every transfer cycle of a write
- o_ioq_data  out  4  read nibble for the current transfer cycle
- o_ioq_busy  out  1  transfer cycles 1..WORD_NIBS-1 in progress
- o_ioq_nib  out  NIB_W  index of the nibble being transferred this cycle
- o_ioq_dirty  out  NUM_REGS  bit r set when a write to register r commits
- i_ioq_dirty_clr  in  NUM_REGS  per-bit clear of o_ioq_dirty
- o_ioq_pins  out  NUM_REGS*WORD_BITS  committed register contents, reg r at bits [r*WORD_BITS +: WORD_BITS]

## Operation
- States: IDLE, XFER. Nibble counter cnt (NIB_W bits); latched sel_q, wr_q; shadow word shd (WORD_BITS-4 bits).
- Start accepted when i_ioq_start=1 and (state==IDLE, or state==XFER with cnt==WORD_NIBS-1). Start in any other XFER cycle is ignored.
- Accepted-start cycle is transfer cycle 0: sel/wr_en latched, cnt -> 1, state -> XFER.
- XFER: cnt increments each cycle; at cnt==WORD_NIBS-1 (last cycle) state -> IDLE unless a new start is accepted (then cnt -> 1, stay XFER, back-to-back with no gap).
- Active sel/wr this cycle: input values in cycle 0, latched values in cycles 1..WORD_NIBS-1.
- o_ioq_nib: 0 in IDLE, cnt in XFER (cycle 0 shows 0).
- Read: o_ioq_data = nibble o_ioq_nib of committed register[active sel], combinational. In IDLE without start, o_ioq_data = nibble 0 of register[i_ioq_sel].
- Write: i_ioq_data of cycle k stored into shd nibble k for k < WORD_NIBS-1. On last cycle, register[sel_q] <= {i_ioq_data, shd}; dirty[sel_q] <= 1. o_ioq_data during a write shows the old committed nibble (no bypass).
- No partial commit: registers change only on a last write cycle.
- Dirty: set takes priority over i_ioq_dirty_clr for the same bit in the same cycle; otherwise clr bit clears.
- Reset (any time, including mid-transaction): state IDLE, cnt 0, shd 0, all registers 0, dirty 0; in-flight write discarded.

## Timing
- Reset values: o_ioq_data 0, o_ioq_busy 0, o_ioq_nib 0, o_ioq_dirty 0, o_ioq_pins 0.
- Transaction length exactly WORD_NIBS cycles; o_ioq_busy high for the final WORD_NIBS-1 of them (low on cycle 0).
- Read data: zero latency, valid in the same cycle as its nibble index.
- Write commit: o_ioq_pins and o_ioq_dirty update on the edge ending the last cycle, visible the cycle after.
- Read of a register in the cycle after its commit returns the new value.
- Max throughput: one word per WORD_NIBS cycles (back-to-back).

## Test plan
- Reset then idle read with sel=2: o_ioq_data=0 for 4 cycles, pins=0, dirty=0, busy=0.
- Write reg1 nibbles 0xD,0xC,0xB,0xA (defaults): pins[31:16] stays 0x0000 for cycles 0..3, becomes 0xABCD after; dirty=4'b0010; a subsequent read of reg1 outputs D,C,B,A with nib 0,1,2,3.
- Back-to-back: write reg0=0x1234, start asserted on its last cycle for read of reg0 -> read yields 4,3,2,1 with no idle cycle; a start in cycle 1 or 2 is ignored (nib keeps counting).
- Reset asserted in cycle 2 of a write of 0xFFFF to reg3 -> reg3 stays 0x0000, dirty[3]=0, state IDLE immediately.
- Dirty: dirty_clr[0]=1 in the same cycle as reg0 commit -> dirty[0]=1; clr next cycle -> 0; other bits untouched.
- Parameter sweep NUM_REGS=8, WORD_NIBS=8: write reg7=0x89ABCDEF -> pins[255:224]=0x89ABCDEF, busy high 7 cycles.
